// File: rtl/rast_iter_pkg.sv
// rast_iter_pkg
// Shared definitions for the rasterizer sample-iteration stage: default
// widths, the iteration FSM state type, the one-hot subsample encodings and
// the helper that turns a subsample rate into a fixed-point step size.

package rast_iter_pkg;

    localparam int DEF_SIGFIG = 24;
    localparam int DEF_RADIX  = 10;
    localparam int DEF_VERTS  = 3;
    localparam int DEF_AXIS   = 3;
    localparam int DEF_COLORS = 3;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } iter_state_t;

    // One-hot subsample rates, expressed in samples per pixel.
    localparam logic [3:0] SUBS_1SPP  = 4'b1000;
    localparam logic [3:0] SUBS_4SPP  = 4'b0100;
    localparam logic [3:0] SUBS_16SPP = 4'b0010;
    localparam logic [3:0] SUBS_64SPP = 4'b0001;

    // Map a subsample rate onto a step in fixed-point units. The highest set
    // bit wins so a malformed (multi-hot) rate still yields a sane step, and
    // an all-zero rate falls back to one sample per pixel.
    function automatic logic [DEF_SIGFIG-1:0] step_decode(
        input logic [3:0] subSample,
        input int         radix
    );
        logic [DEF_SIGFIG-1:0] one;
        one = DEF_SIGFIG'(1);
        if (subSample[3]) begin
            step_decode = one << radix;
        end else if (subSample[2]) begin
            step_decode = one << (radix - 1);
        end else if (subSample[1]) begin
            step_decode = one << (radix - 2);
        end else if (subSample[0]) begin
            step_decode = one << (radix - 3);
        end else begin
            step_decode = one << radix;
        end
    endfunction

endpackage

// File: rtl/sample_iter_ctrl.sv
// sample_iter_ctrl
// Takes one triangle plus its snapped bounding box, then walks every sample
// position inside the box in raster order (x fastest) at the step chosen by
// the subsample rate. While a triangle is being walked the upstream stage is
// held off through halt_RnnnnL.

module sample_iter_ctrl
    import rast_iter_pkg::*;
#(
    parameter int SIGFIG = DEF_SIGFIG,
    parameter int RADIX  = DEF_RADIX,
    parameter int VERTS  = DEF_VERTS,
    parameter int AXIS   = DEF_AXIS,
    parameter int COLORS = DEF_COLORS
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                          validTri_R13H,
    input  logic        [3:0]                             subSample_RnnnnU,
    output logic                                          halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R16U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R16S,
    output logic                                          validSamp_R16H
);

    iter_state_t r_state, w_stateNext;

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri,   w_triNext;
    logic [COLORS-1:0][SIGFIG-1:0]          r_color, w_colorNext;

    logic signed [SIGFIG-1:0] r_llX,   w_llXNext;
    logic signed [SIGFIG-1:0] r_urX,   w_urXNext;
    logic signed [SIGFIG-1:0] r_urY,   w_urYNext;
    logic signed [SIGFIG-1:0] r_sampX, w_sampXNext;
    logic signed [SIGFIG-1:0] r_sampY, w_sampYNext;
    logic        [SIGFIG-1:0] r_step,  w_stepNext;
    logic                     r_valid, w_validNext;

    logic        [SIGFIG-1:0] w_stepIn;
    logic signed [SIGFIG:0]   w_xPlus;
    logic signed [SIGFIG:0]   w_yPlus;
    logic signed [SIGFIG:0]   w_urXExt;
    logic signed [SIGFIG:0]   w_urYExt;
    logic signed [SIGFIG:0]   w_inLlX;
    logic signed [SIGFIG:0]   w_inLlY;
    logic signed [SIGFIG:0]   w_inUrX;
    logic signed [SIGFIG:0]   w_inUrY;
    logic                     w_degenerate;

    assign w_stepIn = SIGFIG'(step_decode(subSample_RnnnnU, RADIX));

    // Candidate next positions are one bit wider than a coordinate, so a
    // step past the most positive coordinate compares as "beyond the box"
    // instead of wrapping around to a negative value.
    assign w_xPlus  = $signed({r_sampX[SIGFIG-1], r_sampX}) + $signed({1'b0, r_step});
    assign w_yPlus  = $signed({r_sampY[SIGFIG-1], r_sampY}) + $signed({1'b0, r_step});
    assign w_urXExt = $signed({r_urX[SIGFIG-1], r_urX});
    assign w_urYExt = $signed({r_urY[SIGFIG-1], r_urY});

    assign w_inLlX = $signed({box_R13S[0][0][SIGFIG-1], box_R13S[0][0]});
    assign w_inLlY = $signed({box_R13S[0][1][SIGFIG-1], box_R13S[0][1]});
    assign w_inUrX = $signed({box_R13S[1][0][SIGFIG-1], box_R13S[1][0]});
    assign w_inUrY = $signed({box_R13S[1][1][SIGFIG-1], box_R13S[1][1]});

    assign w_degenerate = (w_inUrX < w_inLlX) || (w_inUrY < w_inLlY);

    // Next-state and next-sample logic. In WAIT_STATE a valid triangle is
    // captured (and silently dropped if its box is empty); in TEST_STATE the
    // sample advances along x, wraps to the next row, or finishes.
    always_comb begin
        w_stateNext = r_state;
        w_triNext   = r_tri;
        w_colorNext = r_color;
        w_llXNext   = r_llX;
        w_urXNext   = r_urX;
        w_urYNext   = r_urY;
        w_sampXNext = r_sampX;
        w_sampYNext = r_sampY;
        w_stepNext  = r_step;
        w_validNext = r_valid;

        case (r_state)
            WAIT_STATE: begin
                w_validNext = 1'b0;
                if (validTri_R13H) begin
                    w_triNext   = tri_R13S;
                    w_colorNext = color_R13U;
                    w_llXNext   = box_R13S[0][0];
                    w_urXNext   = box_R13S[1][0];
                    w_urYNext   = box_R13S[1][1];
                    w_stepNext  = w_stepIn;
                    if (!w_degenerate) begin
                        w_sampXNext = box_R13S[0][0];
                        w_sampYNext = box_R13S[0][1];
                        w_validNext = 1'b1;
                        w_stateNext = TEST_STATE;
                    end
                end
            end
            TEST_STATE: begin
                if (w_xPlus <= w_urXExt) begin
                    w_sampXNext = w_xPlus[SIGFIG-1:0];
                end else if (w_yPlus <= w_urYExt) begin
                    w_sampXNext = r_llX;
                    w_sampYNext = w_yPlus[SIGFIG-1:0];
                end else begin
                    w_validNext = 1'b0;
                    w_stateNext = WAIT_STATE;
                end
            end
            default: begin
                w_validNext = 1'b0;
                w_stateNext = WAIT_STATE;
            end
        endcase
    end

    // All stage registers; reset aborts any triangle in flight and clears
    // every visible output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_STATE;
            r_tri   <= '0;
            r_color <= '0;
            r_llX   <= '0;
            r_urX   <= '0;
            r_urY   <= '0;
            r_sampX <= '0;
            r_sampY <= '0;
            r_step  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_tri   <= w_triNext;
            r_color <= w_colorNext;
            r_llX   <= w_llXNext;
            r_urX   <= w_urXNext;
            r_urY   <= w_urYNext;
            r_sampX <= w_sampXNext;
            r_sampY <= w_sampYNext;
            r_step  <= w_stepNext;
            r_valid <= w_validNext;
        end
    end

    assign halt_RnnnnL    = (r_state == WAIT_STATE);
    assign tri_R16S       = r_tri;
    assign color_R16U     = r_color;
    assign sample_R16S    = {r_sampY, r_sampX};
    assign validSamp_R16H = r_valid;

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// tb_sample_iter_ctrl
// Self-checking bench for sample_iter_ctrl. A table of boxes and rates is
// expanded by a small raster model into expected samples pushed onto a
// scoreboard queue; a monitor pops and compares whenever the DUT presents a
// valid sample. Hand-written sequences cover the bubble, reset-abort and
// late rate-change cases.

module tb_sample_iter_ctrl;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int TRIW   = VERTS * AXIS * SIGFIG;
    localparam int COLW   = COLORS * SIGFIG;

    logic clk = 1'b0;
    logic rst;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] triIn;
    logic        [COLORS-1:0][SIGFIG-1:0]          colorIn;
    logic signed [1:0][1:0][SIGFIG-1:0]            boxIn;
    logic                                          validIn;
    logic        [3:0]                             subIn;
    logic                                          halt;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] triOut;
    logic        [COLORS-1:0][SIGFIG-1:0]          colorOut;
    logic signed [1:0][SIGFIG-1:0]                 sampleOut;
    logic                                          validOut;

    sample_iter_ctrl #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (triIn),
        .color_R13U       (colorIn),
        .box_R13S         (boxIn),
        .validTri_R13H    (validIn),
        .subSample_RnnnnU (subIn),
        .halt_RnnnnL      (halt),
        .tri_R16S         (triOut),
        .color_R16U       (colorOut),
        .sample_R16S      (sampleOut),
        .validSamp_R16H   (validOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIGFIG-1:0] x;
        logic [SIGFIG-1:0] y;
        logic [TRIW-1:0]   triV;
        logic [COLW-1:0]   colV;
    } exp_t;

    typedef struct {
        logic [3:0] sub;
        int         llx;
        int         lly;
        int         urx;
        int         ury;
        int         expCount;
    } vec_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   failures = 0;
    int   haltLowCount = 0;
    int   samplesSeen = 0;
    bit   monitorEn = 1'b0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic longint benchStep(input logic [3:0] sub);
        casez (sub)
            4'b1???: benchStep = 1024;
            4'b01??: benchStep = 512;
            4'b001?: benchStep = 256;
            4'b0001: benchStep = 128;
            default: benchStep = 1024;
        endcase
    endfunction

    // Raster model: expand one box into its expected sample sequence.
    task automatic pushModel(input vec_t v, input logic [TRIW-1:0] t, input logic [COLW-1:0] c);
        longint step;
        longint xl;
        longint yl;
        exp_t   e;
        step = benchStep(v.sub);
        if (v.urx < v.llx || v.ury < v.lly) return;
        for (yl = v.lly; yl <= v.ury; yl += step) begin
            for (xl = v.llx; xl <= v.urx; xl += step) begin
                e.x    = xl[SIGFIG-1:0];
                e.y    = yl[SIGFIG-1:0];
                e.triV = t;
                e.colV = c;
                expQ.push_back(e);
            end
        end
    endtask

    // Called at posedge+#1 while idle; drives one triangle through its
    // acceptance edge and returns at posedge+#1 of the first sample cycle.
    task automatic applyStimulus(input vec_t v, output logic [TRIW-1:0] t, output logic [COLW-1:0] c);
        t = TRIW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        c = COLW'({$urandom(), $urandom(), $urandom()});
        triIn       = t;
        colorIn     = c;
        boxIn[0][0] = v.llx[SIGFIG-1:0];
        boxIn[0][1] = v.lly[SIGFIG-1:0];
        boxIn[1][0] = v.urx[SIGFIG-1:0];
        boxIn[1][1] = v.ury[SIGFIG-1:0];
        subIn       = v.sub;
        validIn     = 1'b1;
        pushModel(v, t, c);
        checkOutput("halt_before_accept", halt, 1);
        @(posedge clk);
        #1;
        validIn = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || halt !== 1'b1) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("[TB] FAIL %s_timeout actual=pending:%0d required=pending:0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: halt must mirror the state (low exactly while samples flow),
    // and every valid sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (monitorEn) begin
            checkOutput("halt_vs_valid", halt, !validOut);
            if (!halt) haltLowCount++;
            if (validOut) begin
                samplesSeen++;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_sample actual=(%0h,%0h) required=none",
                             sampleOut[0], sampleOut[1]);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("sample_x", sampleOut[0], monExp.x);
                    checkOutput("sample_y", sampleOut[1], monExp.y);
                    checkOutput("sample_tri", $unsigned(triOut), monExp.triV);
                    checkOutput("sample_color", colorOut, monExp.colV);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t            vecs[9];
        vec_t            v;
        logic [TRIW-1:0] tA;
        logic [TRIW-1:0] tB;
        logic [COLW-1:0] cA;
        logic [COLW-1:0] cB;

        vecs[0] = '{4'b1000, 0,       0,    2048,    1024, 6};
        vecs[1] = '{4'b0100, 0,       0,    1024,    512,  6};
        vecs[2] = '{4'b0010, -256,    -256, 0,       0,    4};
        vecs[3] = '{4'b0001, 100,     100,  355,     228,  4};
        vecs[4] = '{4'b0000, 0,       0,    1023,    0,    1};
        vecs[5] = '{4'b1111, 0,       0,    1024,    0,    2};
        vecs[6] = '{4'b1000, 8388000, 0,    8388607, 0,    1};
        vecs[7] = '{4'b0100, -1000,   5,    100,     600,  6};
        vecs[8] = '{4'b0110, 0,       0,    512,     0,    2};

        rst     = 1'b1;
        validIn = 1'b0;
        triIn   = '0;
        colorIn = '0;
        boxIn   = '0;
        subIn   = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_halt", halt, 1);
        checkOutput("reset_valid", validOut, 0);
        checkOutput("reset_sample", $unsigned(sampleOut), 0);
        checkOutput("reset_tri", $unsigned(triOut), 0);
        checkOutput("reset_color", colorOut, 0);
        monitorEn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven boxes and rates.
        for (int i = 0; i < 9; i++) begin
            haltLowCount = 0;
            samplesSeen  = 0;
            applyStimulus(vecs[i], tA, cA);
            waitIdle($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_count", i), samplesSeen, vecs[i].expCount);
            checkOutput($sformatf("vec%0d_haltlow", i), haltLowCount, vecs[i].expCount);
        end

        // Degenerate box is consumed with no samples, then a normal one runs.
        haltLowCount = 0;
        samplesSeen  = 0;
        v = '{4'b1000, 1024, 0, 0, 0, 0};
        applyStimulus(v, tA, cA);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("degen_count", samplesSeen, 0);
        checkOutput("degen_haltlow", haltLowCount, 0);
        samplesSeen = 0;
        applyStimulus(vecs[1], tA, cA);
        waitIdle("after_degen");
        checkOutput("after_degen_count", samplesSeen, 6);

        // Two single-sample triangles offered back-to-back.
        v  = '{4'b1000, 0, 0, 0, 0, 1};
        tA = TRIW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        tB = ~tA;
        cA = COLW'({$urandom(), $urandom(), $urandom()});
        cB = ~cA;
        pushModel(v, tA, cA);
        pushModel(v, tB, cB);
        triIn   = tA;
        colorIn = cA;
        boxIn   = '0;
        subIn   = 4'b1000;
        validIn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_first_valid", validOut, 1);
        triIn   = tB;
        colorIn = cB;
        @(posedge clk);
        #1;
        checkOutput("b2b_bubble_valid", validOut, 0);
        checkOutput("b2b_bubble_halt", halt, 1);
        checkOutput("b2b_bubble_tri", $unsigned(triOut), tA);
        @(posedge clk);
        #1;
        validIn = 1'b0;
        checkOutput("b2b_second_valid", validOut, 1);
        @(posedge clk);
        #1;
        checkOutput("b2b_after_valid", validOut, 0);
        waitIdle("b2b");

        // Reset on the third sample of a six-sample box aborts it.
        samplesSeen  = 0;
        haltLowCount = 0;
        applyStimulus(vecs[0], tA, cA);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_halt", halt, 1);
        checkOutput("abort_valid", validOut, 0);
        checkOutput("abort_sample", $unsigned(sampleOut), 0);
        checkOutput("abort_tri", $unsigned(triOut), 0);
        checkOutput("abort_color", colorOut, 0);
        checkOutput("abort_pending", expQ.size(), 3);
        expQ.delete();
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort_count", samplesSeen, 3);
        checkOutput("abort_haltlow", haltLowCount, 3);

        // Rate change after acceptance only affects the following triangle.
        samplesSeen = 0;
        applyStimulus(vecs[0], tA, cA);
        subIn = 4'b0001;
        waitIdle("late_rate_a");
        checkOutput("late_rate_a_count", samplesSeen, 6);
        samplesSeen = 0;
        v = '{4'b0001, 0, 0, 256, 128, 6};
        applyStimulus(v, tA, cA);
        waitIdle("late_rate_b");
        checkOutput("late_rate_b_count", samplesSeen, 6);

        checkOutput("final_queue_empty", expQ.size(), 0);
        monitorEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
